// File: rtl/bbox_pkg.sv
// Shared constants for the blob bounding-box path: coordinate widths, the packed
// 26-bit box layout and the table controller state encoding.
package bbox_pkg;

    localparam int X_W    = 7;
    localparam int Y_W    = 6;
    localparam int BBOX_W = 26;

    localparam int XO_HI = 25;
    localparam int XO_LO = 19;
    localparam int YO_HI = 18;
    localparam int YO_LO = 13;
    localparam int XN_HI = 12;
    localparam int XN_LO = 6;
    localparam int YN_HI = 5;
    localparam int YN_LO = 0;

    // Cycles FLUSH waits for the last accepted pixel to reach the table
    localparam int FLUSH_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

    function automatic logic [BBOX_W-1:0] pack_box(
        input logic [X_W-1:0] xo,
        input logic [Y_W-1:0] yo,
        input logic [X_W-1:0] xn,
        input logic [Y_W-1:0] yn
    );
        return {xo, yo, xn, yn};
    endfunction

endpackage

// File: rtl/bbox_merge_unit.sv
// Combinational merge of one pixel into a stored box: an empty entry becomes a
// single-point box, a populated entry grows to cover the pixel.
module bbox_merge_unit
    import bbox_pkg::*;
(
    input  logic              entry_valid_i,
    input  logic [BBOX_W-1:0] entry_i,
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    output logic [BBOX_W-1:0] entry_o
);

    logic [X_W-1:0] xo_cur;
    logic [Y_W-1:0] yo_cur;
    logic [X_W-1:0] xn_cur;
    logic [Y_W-1:0] yn_cur;
    logic [X_W-1:0] xo_new;
    logic [Y_W-1:0] yo_new;
    logic [X_W-1:0] xn_new;
    logic [Y_W-1:0] yn_new;

    always_comb begin
        xo_cur = entry_i[XO_HI:XO_LO];
        yo_cur = entry_i[YO_HI:YO_LO];
        xn_cur = entry_i[XN_HI:XN_LO];
        yn_cur = entry_i[YN_HI:YN_LO];

        // Ties keep the stored value
        xo_new = (x_i < xo_cur) ? x_i : xo_cur;
        yo_new = (y_i < yo_cur) ? y_i : yo_cur;
        xn_new = (x_i > xn_cur) ? x_i : xn_cur;
        yn_new = (y_i > yn_cur) ? y_i : yn_cur;

        if (entry_valid_i) begin
            entry_o = pack_box(xo_new, yo_new, xn_new, yn_new);
        end else begin
            entry_o = pack_box(x_i, y_i, x_i, y_i);
        end
    end

endmodule

// File: rtl/bbox_table_ctrl.sv
// Per-frame bounding-box table: accumulates labelled pixels through a two-stage
// merge pipeline, streams populated boxes out at frame end, then clears the table.
module bbox_table_ctrl
    import bbox_pkg::*;
#(
    parameter int LABEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               pix_valid,
    input  logic [LABEL_W-1:0] pix_label,
    input  logic [X_W-1:0]     pix_x,
    input  logic [Y_W-1:0]     pix_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_label,
    output logic [BBOX_W-1:0]  out_bbox,
    output logic [LABEL_W:0]   obj_count,
    output logic               busy,
    output logic               frame_err
);

    localparam int DEPTH = 1 << LABEL_W;
    localparam int CNT_W = LABEL_W + 1;
    localparam logic [LABEL_W-1:0] LAST_IDX = '1;

    state_e state_q;
    state_e state_d;

    logic               flush_cnt_q;
    logic               flush_cnt_d;
    logic [LABEL_W-1:0] scan_idx_q;
    logic [LABEL_W-1:0] scan_idx_d;
    logic [CNT_W-1:0]   obj_count_q;
    logic [CNT_W-1:0]   obj_count_d;
    logic               frame_err_q;
    logic               frame_err_d;

    logic               s1_valid_q;
    logic [LABEL_W-1:0] s1_label_q;
    logic [X_W-1:0]     s1_x_q;
    logic [Y_W-1:0]     s1_y_q;

    logic [DEPTH-1:0]   tbl_valid_q;
    logic [BBOX_W-1:0]  box_mem [DEPTH];

    logic [LABEL_W-1:0] rd_addr;
    logic [BBOX_W-1:0]  rd_entry;
    logic [BBOX_W-1:0]  merged_entry;
    logic               entry_hit;
    logic               drain_advance;
    logic               flush_done;
    logic [CNT_W-1:0]   pop_count;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (frame_start)                         state_d = ST_ACCUM;
            ST_ACCUM: if (frame_end)                           state_d = ST_FLUSH;
            ST_FLUSH: if (flush_done)                          state_d = ST_DRAIN;
            ST_DRAIN: if (drain_advance && scan_idx_q == LAST_IDX) state_d = ST_CLEAR;
            ST_CLEAR:                                          state_d = ST_IDLE;
            default:                                           state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_DRAIN) && tbl_valid_q[scan_idx_q];
        out_label = out_valid ? scan_idx_q : '0;
        out_bbox  = out_valid ? rd_entry : '0;
        obj_count = obj_count_q;
        frame_err = frame_err_q;
    end

    assign flush_done    = (flush_cnt_q == 1'(FLUSH_CYCLES - 1));
    // Empty indices step on without waiting for out_ready
    assign drain_advance = (state_q == ST_DRAIN) &&
                           (!tbl_valid_q[scan_idx_q] || out_ready);

    // ------------------------------------------------------------------
    // Control registers: flush timer, scan index, object count, error flag
    // ------------------------------------------------------------------
    always_comb begin
        pop_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pop_count = pop_count + CNT_W'(tbl_valid_q[i]);
        end
    end

    always_comb begin
        flush_cnt_d = (state_q == ST_FLUSH) ? flush_cnt_q + 1'b1 : 1'b0;
        frame_err_d = frame_err_q | (frame_start && (state_q != ST_IDLE));
        obj_count_d = obj_count_q;
        scan_idx_d  = scan_idx_q;
        if (state_q == ST_FLUSH && flush_done) begin
            obj_count_d = pop_count;
            scan_idx_d  = '0;
        end else if (drain_advance) begin
            scan_idx_d  = scan_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= 1'b0;
            scan_idx_q  <= '0;
            obj_count_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            scan_idx_q  <= scan_idx_d;
            obj_count_q <= obj_count_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stage 1: capture qualified pixels
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= pix_valid && (state_q == ST_ACCUM);
        end
    end

    always_ff @(posedge clk) begin
        s1_label_q <= pix_label;
        s1_x_q     <= pix_x;
        s1_y_q     <= pix_y;
    end

    // ------------------------------------------------------------------
    // Pipeline stage 2: read, merge, write back
    // The table read is asynchronous, so a write at the end of one cycle is
    // already visible to the next cycle's merge and no bypass path is needed.
    // DRAIN shares the read port since the pipeline is empty by then.
    // ------------------------------------------------------------------
    assign rd_addr   = (state_q == ST_DRAIN) ? scan_idx_q : s1_label_q;
    assign rd_entry  = box_mem[rd_addr];
    assign entry_hit = tbl_valid_q[s1_label_q];

    bbox_merge_unit u_merge (
        .entry_valid_i (entry_hit),
        .entry_i       (rd_entry),
        .x_i           (s1_x_q),
        .y_i           (s1_y_q),
        .entry_o       (merged_entry)
    );

    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            box_mem[s1_label_q] <= merged_entry;
        end
    end

    // Only the valid bits are cleared between frames; stale box data is ignored
    always_ff @(posedge clk) begin
        if (rst || state_q == ST_CLEAR) begin
            tbl_valid_q <= '0;
        end else if (s1_valid_q) begin
            tbl_valid_q[s1_label_q] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bbox_table_ctrl.sv
// Randomised frame-level bench for bbox_table_ctrl: a per-label min/max model
// predicts the readout, obj_count, DRAIN timing and the sticky error flag.
module tb_bbox_table_ctrl;

    localparam int LABEL_W   = 4;
    localparam int DEPTH     = 16;
    // FLUSH (2) + full DRAIN scan (16) + CLEAR (1), before any stall cycles
    localparam int BASE_BUSY = 19;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_start;
    logic               frame_end;
    logic               pix_valid;
    logic [LABEL_W-1:0] pix_label;
    logic [6:0]         pix_x;
    logic [5:0]         pix_y;
    logic               out_valid;
    logic               out_ready;
    logic [LABEL_W-1:0] out_label;
    logic [25:0]        out_bbox;
    logic [LABEL_W:0]   obj_count;
    logic               busy;
    logic               frame_err;

    bbox_table_ctrl #(.LABEL_W(LABEL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .pix_valid   (pix_valid),
        .pix_label   (pix_label),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_label   (out_label),
        .out_bbox    (out_bbox),
        .obj_count   (obj_count),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit err_model = 1'b0;
    int last_obj  = 0;
    int q_label[$];
    int q_x[$];
    int q_y[$];
    int q_gap[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_pix(input int l, input int x, input int y, input int gap);
        q_label.push_back(l);
        q_x.push_back(x);
        q_y.push_back(y);
        q_gap.push_back(gap);
    endtask

    task automatic clear_pix();
        q_label.delete();
        q_x.delete();
        q_y.delete();
        q_gap.delete();
    endtask

    task automatic junk_pix();
        pix_label = LABEL_W'($urandom_range(0, DEPTH - 1));
        pix_x     = 7'($urandom_range(0, 127));
        pix_y     = 6'($urandom_range(0, 63));
    endtask

    function automatic int pack(input int xo, input int yo, input int xn, input int yn);
        return (xo << 19) | (yo << 13) | (xn << 6) | yn;
    endfunction

    // ready_mode: 0 always ready, 1 random, 2 low for the first 4 valid cycles
    task automatic run_frame(input int ready_mode, input bit end_with_last, input bit coincide,
                             input int start_at, input bit rst_mid);
        bit mv[DEPTH];
        int mxo[DEPTH];
        int myo[DEPTH];
        int mxn[DEPTH];
        int myn[DEPTH];
        int exp_l[$];
        int exp_b[$];
        int got_l[$];
        int got_b[$];
        int busy_cycles;
        int stalls;
        int nvalid;
        int l;
        bit hold;
        bit aborted;
        bit rdy;
        logic [LABEL_W-1:0] hold_l;
        logic [25:0] hold_b;

        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        foreach (q_label[i]) begin
            l = q_label[i];
            if (!mv[l]) begin
                mv[l] = 1'b1;
                mxo[l] = q_x[i]; mxn[l] = q_x[i];
                myo[l] = q_y[i]; myn[l] = q_y[i];
            end else begin
                if (q_x[i] < mxo[l]) mxo[l] = q_x[i];
                if (q_x[i] > mxn[l]) mxn[l] = q_x[i];
                if (q_y[i] < myo[l]) myo[l] = q_y[i];
                if (q_y[i] > myn[l]) myn[l] = q_y[i];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (mv[i]) begin
                exp_l.push_back(i);
                exp_b.push_back(pack(mxo[i], myo[i], mxn[i], myn[i]));
            end
        end

        // A pixel in IDLE and one alongside frame_start must both be dropped
        pix_valid = 1'b1; junk_pix();
        step();
        frame_start = 1'b1; frame_end = coincide; junk_pix();
        step();
        frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0;
        check_eq("busy_accum", busy, 1);
        check_eq("obj_hold", obj_count, last_obj);

        foreach (q_label[i]) begin
            for (int g = 0; g < q_gap[i]; g++) begin
                pix_valid = 1'b0; junk_pix();
                step();
            end
            pix_valid = 1'b1;
            pix_label = LABEL_W'(q_label[i]);
            pix_x     = 7'(q_x[i]);
            pix_y     = 6'(q_y[i]);
            frame_end = end_with_last && (i == q_label.size() - 1);
            step();
        end
        pix_valid = 1'b0;
        if (!(end_with_last && q_label.size() > 0)) begin
            frame_end = 1'b1;
            step();
        end
        frame_end = 1'b0;

        busy_cycles = 0; stalls = 0; nvalid = 0; hold = 1'b0; aborted = 1'b0;
        hold_l = '0; hold_b = '0;
        for (int c = 0; c < 400 && busy; c++) begin
            busy_cycles++;
            if (hold) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_label", out_label, hold_l);
                check_eq("hold_bbox", out_bbox, hold_b);
            end
            if (out_valid) begin
                if (rst_mid) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    check_eq("rst_out_valid", out_valid, 0);
                    check_eq("rst_busy", busy, 0);
                    check_eq("rst_obj_count", obj_count, 0);
                    err_model = 1'b0;
                    last_obj  = 0;
                    aborted   = 1'b1;
                    break;
                end
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = (nvalid >= 4);
                endcase
                nvalid++;
                out_ready = rdy;
                if (rdy) begin
                    got_l.push_back(int'(out_label));
                    got_b.push_back(int'(out_bbox));
                    hold = 1'b0;
                end else begin
                    stalls++;
                    hold = 1'b1; hold_l = out_label; hold_b = out_bbox;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                hold = 1'b0;
            end
            if (c == start_at) begin
                frame_start = 1'b1;
                err_model   = 1'b1;
            end
            frame_end = ($urandom_range(0, 7) == 0);
            step();
            frame_start = 1'b0;
            frame_end   = 1'b0;
        end
        out_ready = 1'b0;

        check_eq("drain_done", busy, 0);
        if (!aborted) begin
            check_eq("busy_cycles", busy_cycles, BASE_BUSY + stalls);
            check_eq("n_entries", got_l.size(), exp_l.size());
            for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
                check_eq($sformatf("label[%0d]", i), got_l[i], exp_l[i]);
                check_eq($sformatf("bbox[%0d]", i), got_b[i], exp_b[i]);
            end
            check_eq("obj_count", obj_count, exp_l.size());
            last_obj = exp_l.size();
        end
        check_eq("frame_err", frame_err, err_model);
        $display("frame: pixels=%0d expected=%0d received=%0d stalls=%0d busy=%0d reset=%0d",
                 q_label.size(), exp_l.size(), got_l.size(), stalls, busy_cycles, aborted);
        clear_pix();
    endtask

    initial begin
        int npix;
        int lmax;
        rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0;
        pix_label = '0; pix_x = '0; pix_y = '0; out_ready = 1'b0;
        repeat (3) step();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_label", out_label, 0);
        check_eq("rst_out_bbox", out_bbox, 0);
        check_eq("rst_obj_count", obj_count, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        step();
        check_eq("idle_busy", busy, 0);

        add_pix(3, 10, 5, 0);
        run_frame(0, 1'b0, 1'b0, -1, 1'b0);

        add_pix(1, 20, 30, 0); add_pix(1, 5, 40, 0); add_pix(1, 60, 2, 0);
        run_frame(0, 1'b1, 1'b0, -1, 1'b0);
        add_pix(1, 20, 30, 3); add_pix(1, 5, 40, 3); add_pix(1, 60, 2, 3);
        run_frame(1, 1'b0, 1'b0, -1, 1'b0);

        add_pix(7, 100, 50, 0); add_pix(2, 3, 4, 1); add_pix(7, 90, 60, 0);
        run_frame(2, 1'b0, 1'b0, -1, 1'b0);

        run_frame(0, 1'b0, 1'b1, -1, 1'b0);
        add_pix(0, 0, 0, 0);
        run_frame(0, 1'b1, 1'b0, -1, 1'b0);

        add_pix(4, 127, 63, 0); add_pix(9, 64, 32, 0); add_pix(15, 1, 1, 2);
        run_frame(1, 1'b0, 1'b0, 5, 1'b0);

        add_pix(6, 11, 12, 0); add_pix(12, 13, 14, 0);
        run_frame(2, 1'b0, 1'b0, -1, 1'b1);
        add_pix(5, 33, 22, 0);
        run_frame(0, 1'b0, 1'b0, -1, 1'b0);

        for (int f = 0; f < 12; f++) begin
            npix = $urandom_range(0, 40);
            lmax = (f % 2 == 0) ? 3 : DEPTH - 1;
            for (int p = 0; p < npix; p++) begin
                add_pix($urandom_range(0, lmax), $urandom_range(0, 127), $urandom_range(0, 63),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 5) == 0) ? $urandom_range(0, 18) : -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
